// File: rtl/edge_log_stream.sv
// Streaming 5x5 Laplacian-of-Gaussian edge filter: raster pixels in, saturated LoG response out.
// Define EDGE_LOG_THRESH_EN to add a per-frame binary threshold (thresh port) after saturation.
module edge_log_stream #(
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned ACC_W      = PIX_W + 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
`ifdef EDGE_LOG_THRESH_EN
    input  logic [PIX_W-1:0] thresh,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_last
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);
    localparam int KERNEL [5][5] = '{
        '{-1, -3, -4, -3, -1},
        '{-3,  0,  6,  0, -3},
        '{-4,  6, 21,  6, -4},
        '{-3,  0,  6,  0, -3},
        '{-1, -3, -4, -3, -1}
    };

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          mode_q;
`ifdef EDGE_LOG_THRESH_EN
    logic [PIX_W-1:0] thresh_q;
`endif

    logic [PIX_W-1:0] line_buf [4][IMG_WIDTH];
    logic [PIX_W-1:0] win_q [5][4];
    logic [PIX_W-1:0] win [5][5];

    logic en, accept, win_valid, frame_start, col_end, row_end;
    logic signed [ACC_W-1:0] win_sum, s1_sum_q, mag;
    logic s1_valid_q, s1_last_q;
    logic [PIX_W-1:0] sat, s2_pix;

    assign en          = out_ready | ~out_valid;
    assign in_ready    = en;
    assign accept      = in_valid & en;
    assign win_valid   = (row_q >= RW'(4)) && (col_q >= CW'(4));
    assign frame_start = (row_q == '0) && (col_q == '0);
    assign col_end     = (col_q == CW'(IMG_WIDTH - 1));
    assign row_end     = (row_q == RW'(IMG_HEIGHT - 1));

    // Full window = four stored columns plus the column formed by the incoming pixel and the
    // line buffers, so the sum is ready at the accepting edge (row 0 of win is the oldest line).
    always_comb begin
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                win[r][c] = win_q[r][c];
            end
        end
        win[0][4] = line_buf[3][col_q];
        win[1][4] = line_buf[2][col_q];
        win[2][4] = line_buf[1][col_q];
        win[3][4] = line_buf[0][col_q];
        win[4][4] = in_pixel;
    end

    always_comb begin
        win_sum = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                win_sum = win_sum + ACC_W'(KERNEL[r][c]) * $signed(ACC_W'(win[r][c]));
            end
        end
    end

    always_comb begin
        mag = (mode_q && (s1_sum_q < 0)) ? -s1_sum_q : s1_sum_q;
        if (mag < 0) begin
            sat = '0;
        end else if (mag > PIX_MAX) begin
            sat = '1;
        end else begin
            sat = mag[PIX_W-1:0];
        end
`ifdef EDGE_LOG_THRESH_EN
        s2_pix = (sat >= thresh_q) ? '1 : '0;
`else
        s2_pix = sat;
`endif
    end

    // Buffers and window need no reset: a window is only used once it holds current-frame data.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf[0][col_q] <= in_pixel;
            for (int k = 1; k < 4; k++) begin
                line_buf[k][col_q] <= line_buf[k-1][col_q];
            end
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][3] <= win[r][4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            mode_q     <= 1'b0;
`ifdef EDGE_LOG_THRESH_EN
            thresh_q   <= '0;
`endif
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sum_q   <= '0;
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_last   <= 1'b0;
        end else begin
            if (accept) begin
                if (frame_start) begin
                    mode_q   <= mode;
`ifdef EDGE_LOG_THRESH_EN
                    thresh_q <= thresh;
`endif
                end
                if (col_end) begin
                    col_q <= '0;
                    row_q <= row_end ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            if (en) begin
                s1_valid_q <= accept & win_valid;
                s1_last_q  <= accept & row_end & col_end;
                if (accept & win_valid) begin
                    s1_sum_q <= win_sum;
                end
                out_valid <= s1_valid_q;
                out_last  <= s1_valid_q & s1_last_q;
                if (s1_valid_q) begin
                    out_pixel <= s2_pix;
                end
            end
        end
    end

endmodule

// File: doc/edge_log_stream.md
# edge_log_stream

Streaming 5x5 Laplacian-of-Gaussian edge filter for the post-decode pixel path. Accepts one raster-order pixel per cycle over a valid/ready handshake, builds the 5x5 window internally from four line buffers, and emits the signed LoG response with correct-width arithmetic. It adds clamp or absolute-value output modes, per-frame position tracking and an end-of-frame marker.

## Interface
- `IMG_WIDTH`, default 64: pixels per line (≥5).
- `IMG_HEIGHT`, default 64: lines per frame (≥5).
- `PIX_W`, default 8: pixel width, unsigned.
- `ACC_W`, default PIX_W+8: signed accumulator width; 16 covers the full range at PIX_W=8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mode` in 1: 0 = clamp the signed result to [0, 2^PIX_W−1]; 1 = clamp |result| to 2^PIX_W−1.
- `in_valid` in 1: input pixel valid.
- `in_ready` out 1: block accepts the pixel this cycle.
- `in_pixel` in PIX_W: raster-order pixel.
- `out_valid` out 1: output pixel valid.
- `out_ready` in 1: downstream accepts.
- `out_pixel` out PIX_W: filtered pixel.
- `out_last` out 1: set with the final output pixel of a frame.

## Operation
- Kernel, fixed and symmetric, rows top to bottom:
  - [-1 -3 -4 -3 -1]
  - [-3 0 6 0 -3]
  - [-4 6 21 6 -4]
  - [-3 0 6 0 -3]
  - [-1 -3 -4 -3 -1]
  - Coefficient sum = 1.
- Arithmetic: pixels are zero-extended, then accumulated signed in ACC_W bits with no intermediate truncation. At PIX_W=8 the range is −11220..+11475.
- Output stage: saturating per `mode`. Mode 0: negative → 0; >255 → 255. Mode 1: |x| then >255 → 255.
- Position counters `col` (0..IMG_WIDTH−1) and `row` (0..IMG_HEIGHT−1) advance on each accepted pixel.
  - `col` wraps to 0 and increments `row`.
  - At (IMG_HEIGHT−1, IMG_WIDTH−1) both wrap to 0 and the next frame starts.
- Line buffers: four memories of IMG_WIDTH×PIX_W, shifted once per accepted pixel. A 5x5 register window holds the last five columns. Memories are not cleared on reset.
- Window valid: only when the accepted pixel has row ≥ 4 and col ≥ 4. The window then covers rows row−4..row and cols col−4..col, and the output corresponds to image position (row−2, col−2).
  - Other accepted pixels update buffers and counters but produce no output.
  - Output count per frame = (IMG_WIDTH−4)×(IMG_HEIGHT−4); borders are dropped.
- `mode` is sampled when pixel (0,0) is accepted and held for the whole frame.
- `out_last` is asserted with the output produced from input (IMG_HEIGHT−1, IMG_WIDTH−1).

## Timing
- Pipeline: S1 registers the window sum; S2 registers the saturated result onto `out_pixel`, `out_valid` and `out_last`.
- Global enable `en = out_ready | ~out_valid`. `in_ready = en`, combinational from `out_ready` and state only (no path from `in_valid`).
- Latency: a pixel accepted in cycle t with a valid window gives `out_valid` in cycle t+2 when no stall occurs. Sustained throughput is 1 pixel/cycle.
- Stall: while `out_valid & ~out_ready`:
  - `out_pixel` and `out_last` are held.
  - S1 is frozen.
  - `in_ready` = 0.
- Bubbles (`in_valid` = 0 or non-window pixels) propagate as invalid S1/S2 slots and do not stall input.
- Reset values: `out_valid` = 0, `out_pixel` = 0, `out_last` = 0, S1 valid = 0, `row` = `col` = 0, registered mode = 0. `in_ready` = 1 in the cycle after reset deasserts.
- Reset mid-frame: in-flight outputs are discarded and counters restart at (0,0). The first output of the new frame follows the acceptance of pixel (4,4). Stale buffer contents are never used.

## Configuration
- `EDGE_LOG_THRESH_EN` defined:
  - Adds input `thresh` (PIX_W).
  - After mode saturation, `out_pixel` = all-ones if value ≥ `thresh`, else 0.
  - `thresh` is sampled with `mode` at pixel (0,0).
  - Latency is unchanged; the compare lives in S2.
- Undefined: no `thresh` port; `out_pixel` is the saturated value.

## Test plan
- Flat frame of 100 (64x64), `mode` = 0, `out_ready` = 1 → 3600 outputs, all 100; `out_last` only on the 3600th; first output 2 cycles after accepting (4,4).
- All-zero frame except 10 at (10,10), `mode` = 0 → output at (10,10) = 210; output at (8,8) = 0 (−10 clamped); output at (10,12) = 0 (−40 clamped).
- Same frame, `mode` = 1 → (10,10) = 210; (8,8) = 10; (10,12) = 40. Flat-255 frame → 255 in both modes.
- `out_ready` low for 5 cycles mid-stream → `out_pixel` stable, `in_ready` = 0 throughout; output sequence is identical to the unstalled run with no loss or duplication.
- Assert `rst` for 1 cycle at row 20 of a frame → `out_valid` = 0 next cycle; new frame of 100s gives its first output only after (4,4) is accepted, and that output is 100.
- With `EDGE_LOG_THRESH_EN`, `thresh` = 150 and the impulse frame in `mode` 0 → (10,10) = 255; all other outputs = 0.
